// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory subsystem: FSM state encoding, port ids,
// and the word-address legality check used by the memory arbiter.
package mips_pkg;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

    // Misaligned or past the last full word of the memory.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] memsize);
        return (addr[1:0] != 2'b00) || (addr > memsize - 32'(WORD_BYTES));
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports plus the memory-side bus of the memory arbiter.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_read;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_write;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_read, mem_raddr, mem_write, mem_waddr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_read, mem_raddr, mem_write, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/mem.sv
// Word-organised memory, combinational read and write committed on the clock edge.
module mem #(
    parameter int MEMSIZE = 1024
) (
    input  logic        clk,
    input  logic        read,
    input  logic [31:0] raddr,
    output logic [31:0] rdata,
    input  logic        write,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata
);
    localparam int AW = $clog2(MEMSIZE / 4);

    logic [31:0] words [MEMSIZE / 4];
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{raddr[31:AW+2], raddr[1:0], waddr[31:AW+2], waddr[1:0]};
    assign rdata = read ? words[raddr[AW+1:2]] : '0;

    always_ff @(posedge clk) begin
        if (write) words[waddr[AW+1:2]] <= wdata;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word memory between the fetch and data ports;
// one access at a time, IDLE -> ACCESS -> RESP, single-cycle ack on the winning port.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int MEMSIZE = 1024
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    state_t      state, state_nx;
    port_t       last_gnt, cmd_port, gnt;
    logic        cmd_we, cmd_err, resp_err;
    logic [31:0] cmd_addr, cmd_wdata, resp_rdata;
    logic        gnt_we;
    logic [31:0] gnt_addr, gnt_wdata;
    logic        any_req, rd_en, wr_en;

    assign any_req = bus.i_req | bus.d_req;
    assign rd_en   = (state == ST_ACCESS) && !cmd_err && !cmd_we;
    assign wr_en   = (state == ST_ACCESS) && !cmd_err && cmd_we;

    // On conflict the port that did not win last time gets the grant.
    always_comb begin
        if (bus.i_req && bus.d_req) gnt = (last_gnt == PORT_D) ? PORT_I : PORT_D;
        else if (bus.i_req)         gnt = PORT_I;
        else                        gnt = PORT_D;
        gnt_we    = (gnt == PORT_D) && bus.d_we;
        gnt_addr  = (gnt == PORT_I) ? bus.i_addr : bus.d_addr;
        gnt_wdata = (gnt == PORT_D) ? bus.d_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_gnt   <= PORT_D;
            cmd_port   <= PORT_I;
            cmd_we     <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && any_req) begin
                last_gnt  <= gnt;
                cmd_port  <= gnt;
                cmd_we    <= gnt_we;
                cmd_addr  <= gnt_addr;
                cmd_wdata <= gnt_wdata;
                cmd_err   <= addr_bad(gnt_addr, 32'(MEMSIZE));
            end
            if (state == ST_ACCESS) begin
                resp_rdata <= rd_en ? bus.mem_rdata : '0;
                resp_err   <= cmd_err;
            end
        end
    end

    // Outputs are forced low during reset so a write caught in ACCESS never commits.
    always_comb begin
        state_nx      = state;
        bus.i_ack     = 1'b0;
        bus.i_rdata   = '0;
        bus.i_err     = 1'b0;
        bus.d_ack     = 1'b0;
        bus.d_rdata   = '0;
        bus.d_err     = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_raddr = '0;
        bus.mem_write = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        case (state)
            ST_IDLE:   if (any_req) state_nx = ST_ACCESS;
            ST_ACCESS: begin
                state_nx = ST_RESP;
                if (!rst) begin
                    bus.mem_read  = rd_en;
                    bus.mem_raddr = rd_en ? cmd_addr : '0;
                    bus.mem_write = wr_en;
                    bus.mem_waddr = wr_en ? cmd_addr : '0;
                    bus.mem_wdata = wr_en ? cmd_wdata : '0;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
                if (!rst) begin
                    if (cmd_port == PORT_I) begin
                        bus.i_ack   = 1'b1;
                        bus.i_rdata = resp_rdata;
                        bus.i_err   = resp_err;
                    end else begin
                        bus.d_ack   = 1'b1;
                        bus.d_rdata = resp_rdata;
                        bus.d_err   = resp_err;
                    end
                end
            end
            default:   state_nx = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter + mem: queued requesters per port, transaction-level
// reference model of grants, latency and memory contents, checked every cycle.
module tb_mem_arbiter;
    localparam int MEMSIZE = 1024;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.MEMSIZE(MEMSIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

    mem #(.MEMSIZE(MEMSIZE)) u_mem (
        .clk(clk), .read(bus.mem_read), .raddr(bus.mem_raddr), .rdata(bus.mem_rdata),
        .write(bus.mem_write), .waddr(bus.mem_waddr), .wdata(bus.mem_wdata)
    );

    int checks = 0, failures = 0, k = 0;

    // requesters
    req_t iq[$], dq[$];
    req_t i_cur, d_cur;
    bit   i_act = 0, d_act = 0;
    int   i_req_cyc = 0, d_req_cyc = 0, i_ack_seen = 0, d_ack_seen = 0, wr_cnt = 0;
    logic [31:0] last_i_rdata, last_d_rdata;
    logic        last_d_err;
    bit   ack_log[$];
    int   d_ack_cycs[$];

    // transaction-level reference model
    logic [31:0] ref_mem [256];
    bit          last_d = 1'b1;
    int          acc_cyc = -1, resp_cyc = -1, free_at = 0;
    bit          e_rd, e_wr, e_port_d, e_err;
    logic [31:0] e_addr, e_wdata, e_rdata;
    bit          pw = 0;
    int          pw_cyc = 0;
    logic [31:0] pw_addr, pw_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic        x_rd, x_wr, x_ia, x_da, x_ie, x_de;
        logic [31:0] x_ra, x_wa, x_wd, x_ir, x_dr;
        @(negedge clk);
        k++;
        {x_rd, x_wr, x_ia, x_da, x_ie, x_de} = '0;
        {x_ra, x_wa, x_wd, x_ir, x_dr} = '0;
        if (!rst && k == acc_cyc) begin
            x_rd = e_rd;
            x_wr = e_wr;
            x_ra = e_rd ? e_addr : '0;
            x_wa = e_wr ? e_addr : '0;
            x_wd = e_wr ? e_wdata : '0;
        end
        if (!rst && k == resp_cyc) begin
            if (e_port_d) begin x_da = 1'b1; x_dr = e_rdata; x_de = e_err; end
            else          begin x_ia = 1'b1; x_ir = e_rdata; x_ie = e_err; end
        end
        chk("mem_read",  32'(bus.mem_read),  32'(x_rd));
        chk("mem_raddr", bus.mem_raddr,      x_ra);
        chk("mem_write", 32'(bus.mem_write), 32'(x_wr));
        chk("mem_waddr", bus.mem_waddr,      x_wa);
        chk("mem_wdata", bus.mem_wdata,      x_wd);
        chk("i_ack",     32'(bus.i_ack),     32'(x_ia));
        chk("i_rdata",   bus.i_rdata,        x_ir);
        chk("i_err",     32'(bus.i_err),     32'(x_ie));
        chk("d_ack",     32'(bus.d_ack),     32'(x_da));
        chk("d_rdata",   bus.d_rdata,        x_dr);
        chk("d_err",     32'(bus.d_err),     32'(x_de));
        chk("two_acks",  32'(bus.i_ack & bus.d_ack), 32'd0);
        if (bus.mem_write === 1'b1) wr_cnt++;
        if (bus.i_ack === 1'b1) begin ack_log.push_back(1'b0); i_ack_seen = k; last_i_rdata = bus.i_rdata; end
        if (bus.d_ack === 1'b1) begin
            ack_log.push_back(1'b1); d_ack_seen = k; d_ack_cycs.push_back(k);
            last_d_rdata = bus.d_rdata; last_d_err = bus.d_err;
        end
        if (pw && k == pw_cyc) begin ref_mem[pw_addr[9:2]] = pw_data; pw = 0; end
        if (!rst && k == resp_cyc) begin
            if (e_port_d) d_act = 0; else i_act = 0;
        end
    endtask

    task automatic drive();
        bit   to_d, bad;
        req_t r;
        if (!i_act && iq.size() > 0) begin i_cur = iq.pop_front(); i_act = 1; i_req_cyc = k; end
        if (!d_act && dq.size() > 0) begin d_cur = dq.pop_front(); d_act = 1; d_req_cyc = k; end
        bus.i_req   = i_act;
        bus.i_addr  = i_act ? i_cur.addr : '0;
        bus.d_req   = d_act;
        bus.d_we    = d_act & d_cur.we;
        bus.d_addr  = d_act ? d_cur.addr : '0;
        bus.d_wdata = d_act ? d_cur.data : '0;
        if (!rst && k >= free_at && (i_act || d_act)) begin
            to_d   = (i_act && d_act) ? !last_d : d_act;
            last_d = to_d;
            r      = to_d ? d_cur : i_cur;
            if (!to_d) r.we = 1'b0;
            bad      = (r.addr % 4 != 0) || (r.addr > 32'(MEMSIZE - 4));
            acc_cyc  = k + 1;
            resp_cyc = k + 2;
            free_at  = k + 3;
            e_rd     = !bad && !r.we;
            e_wr     = !bad && r.we;
            e_addr   = r.addr;
            e_wdata  = r.data;
            e_port_d = to_d;
            e_err    = bad;
            e_rdata  = e_rd ? ref_mem[r.addr[9:2]] : '0;
            if (e_wr) begin pw = 1; pw_cyc = k + 2; pw_addr = r.addr; pw_data = r.data; end
        end
    endtask

    task automatic step();
        sample();
        drive();
    endtask

    task automatic drain();
        int b = 0;
        while ((iq.size() > 0 || dq.size() > 0 || i_act || d_act || k < free_at) && b < 400) begin
            step();
            b++;
        end
        chk("drain_bound", 32'(b < 400), 32'd1);
    endtask

    // Called after sample() in place of drive(): hold reset for n cycles, then release.
    task automatic do_reset(input int n);
        rst = 1'b1;
        acc_cyc = -1; resp_cyc = -1; pw = 0; last_d = 1'b1;
        i_act = 0; d_act = 0; iq.delete(); dq.delete();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        #1;
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
        chk("rst_d_ack",     32'(bus.d_ack),     32'd0);
        chk("rst_i_ack",     32'(bus.i_ack),     32'd0);
        repeat (n) sample();
        rst = 1'b0;
        free_at = k;
        drive();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 8)
            0:       return 32'h3FC;
            1:       return 32'(($urandom % 32) * 4 + 1 + ($urandom % 3));
            2:       return 32'h400;
            3:       return 32'hFFFF_FFFC;
            default: return 32'(($urandom % 32) * 4);
        endcase
    endfunction

    initial begin
        int k0, w0;
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

        // reset held two cycles, then idle
        sample(); sample();
        rst = 1'b0; free_at = k; drive();
        repeat (5) step();

        // store then load / fetch of the same word
        w0 = wr_cnt;
        dq.push_back({1'b1, 32'h10, 32'hDEAD_BEEF});
        drain();
        chk("st_latency", 32'(d_ack_seen - d_req_cyc), 32'd2);
        chk("st_wr_cycles", 32'(wr_cnt - w0), 32'd1);
        dq.push_back({1'b0, 32'h10, 32'h0});
        drain();
        chk("ld_data", last_d_rdata, 32'hDEAD_BEEF);
        chk("ld_err", 32'(last_d_err), 32'd0);
        iq.push_back({1'b0, 32'h10, 32'h0});
        drain();
        chk("if_data", last_i_rdata, 32'hDEAD_BEEF);

        // give every word the later tests read a known value
        for (int i = 0; i < 32; i++) dq.push_back({1'b1, 32'(i * 4), (i == 8) ? 32'h0 : $urandom});
        dq.push_back({1'b1, 32'h3FC, 32'h1111_2222});
        drain();

        // simultaneous requests: fetch first, then data
        iq.push_back({1'b0, 32'h10, 32'h0});
        dq.push_back({1'b0, 32'h14, 32'h0});
        step();
        k0 = k;
        drain();
        chk("conf_i_lat", 32'(i_ack_seen - k0), 32'd2);
        chk("conf_d_lat", 32'(d_ack_seen - k0), 32'd5);

        // continuous dual requests alternate I,D,I,D
        ack_log.delete();
        for (int i = 0; i < 4; i++) begin
            iq.push_back({1'b0, 32'(i * 8), 32'h0});
            dq.push_back({1'b0, 32'(i * 8 + 4), 32'h0});
        end
        drain();
        chk("alt_count", 32'(ack_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk("alt_order", (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hFFFF_FFFF, 32'(i % 2));

        // address errors and boundaries
        dq.push_back({1'b0, 32'h12, 32'h0});
        drain();
        chk("err12_err", 32'(last_d_err), 32'd1);
        chk("err12_data", last_d_rdata, 32'h0);
        dq.push_back({1'b1, 32'h3FC, 32'hCAFE_F00D});
        dq.push_back({1'b1, 32'h3FD, 32'h5555_5555});
        dq.push_back({1'b1, 32'h400, 32'hAAAA_AAAA});
        drain();
        chk("err400_err", 32'(last_d_err), 32'd1);
        dq.push_back({1'b0, 32'h3FC, 32'h0});
        drain();
        chk("top_word", last_d_rdata, 32'hCAFE_F00D);

        // reset during the ACCESS cycle of a store drops it
        dq.push_back({1'b1, 32'h20, 32'h1234_5678});
        step();
        sample();
        do_reset(1);
        w0 = d_ack_seen;
        repeat (4) step();
        chk("midrst_no_ack", 32'(d_ack_seen), 32'(w0));
        dq.push_back({1'b0, 32'h20, 32'h0});
        drain();
        chk("midrst_word", last_d_rdata, 32'h0);

        // back-to-back loads on the data port
        d_ack_cycs.delete();
        for (int i = 0; i < 4; i++) dq.push_back({1'b0, 32'(i * 4), 32'h0});
        drain();
        chk("b2b_count", 32'(d_ack_cycs.size()), 32'd4);
        for (int i = 1; i < 4 && i < d_ack_cycs.size(); i++)
            chk("b2b_spacing", 32'(d_ack_cycs[i] - d_ack_cycs[i-1]), 32'd3);

        // randomized traffic on both ports
        for (int c = 0; c < 400; c++) begin
            if (iq.size() == 0 && !i_act && ($urandom % 3) == 0)
                iq.push_back({1'b0, rand_addr(), 32'h0});
            if (dq.size() == 0 && !d_act && ($urandom % 3) == 0)
                dq.push_back({1'($urandom % 2), rand_addr(), 32'($urandom)});
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
